// File: rtl/schedule.sv
// Phase scheduler for the AliSim sequence-simulation core.
// Walks seed -> root -> per-node evolve/write/next -> done and owns the PRNG.
module schedule #(
    parameter int SEQ_LEN   = 8,
    parameter int NUM_NODES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seed_ID,
    output logic [2:0] state
);

    localparam int SW = $clog2(SEQ_LEN) + 1;
    localparam int NW = $clog2(NUM_NODES) + 1;

    localparam logic [SW-1:0] SITE_LAST = SW'(SEQ_LEN - 1);
    localparam logic [NW-1:0] NODE_LAST = NW'(NUM_NODES - 1);

    localparam logic [2:0] IDLE   = 3'b000;
    localparam logic [2:0] SEED   = 3'b001;
    localparam logic [2:0] ROOT   = 3'b010;
    localparam logic [2:0] EVOLVE = 3'b011;
    localparam logic [2:0] WRITE  = 3'b100;
    localparam logic [2:0] NEXT   = 3'b101;
    localparam logic [2:0] DONE   = 3'b110;

    localparam logic [15:0] LFSR_RST  = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [SW-1:0] site_cnt;
    logic [NW-1:0] node_cnt;
    logic [15:0]   lfsr;

    logic site_last;
    logic node_last;
    logic seed_ld;
    logic site_en;
    logic node_inc;

    assign site_last = (site_cnt == SITE_LAST);
    assign node_last = (node_cnt == NODE_LAST);
    assign state     = state_q;

    // phase register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-phase selection; the unused 111 code falls back to IDLE
    always_comb begin
        state_d = IDLE;
        unique case (state_q)
            IDLE:    state_d = SEED;
            SEED:    state_d = ROOT;
            ROOT:    state_d = site_last ? EVOLVE : ROOT;
            EVOLVE:  state_d = site_last ? WRITE : EVOLVE;
            WRITE:   state_d = NEXT;
            NEXT:    state_d = node_last ? DONE : EVOLVE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // per-phase datapath controls
    always_comb begin
        seed_ld  = 1'b0;
        site_en  = 1'b0;
        node_inc = 1'b0;
        unique case (state_q)
            SEED:    seed_ld  = 1'b1;
            ROOT:    site_en  = 1'b1;
            EVOLVE:  site_en  = 1'b1;
            NEXT:    node_inc = !node_last;
            default: ;
        endcase
    end

    // site/node counters and the Galois PRNG
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            site_cnt <= '0;
            node_cnt <= '0;
            lfsr     <= LFSR_RST;
        end else begin
            if (seed_ld) begin
                lfsr     <= {seed_ID, ~seed_ID};
                site_cnt <= '0;
                node_cnt <= '0;
            end
            if (site_en) begin
                lfsr     <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
                site_cnt <= site_last ? '0 : site_cnt + 1'b1;
            end
            if (node_inc) begin
                node_cnt <= node_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_schedule.sv
// Bench for the phase scheduler.
// Reference phase/PRNG model feeds a scoreboard; a vector table spot-checks phases.
module tb_schedule;

    localparam logic [2:0] IDLE   = 3'b000;
    localparam logic [2:0] SEED   = 3'b001;
    localparam logic [2:0] ROOT   = 3'b010;
    localparam logic [2:0] EVOLVE = 3'b011;
    localparam logic [2:0] WRITE  = 3'b100;
    localparam logic [2:0] NEXT   = 3'b101;
    localparam logic [2:0] DONE   = 3'b110;

    logic       clk = 1'b0;
    logic       reset;
    logic       rst_sw;
    logic [7:0] seed_ID;
    logic [7:0] seed_sw;
    logic [2:0] state;
    logic [2:0] state_sw;

    always #5 clk = ~clk;

    schedule u_dut (
        .clk    (clk),
        .reset  (reset),
        .seed_ID(seed_ID),
        .state  (state)
    );

    schedule #(
        .SEQ_LEN  (1),
        .NUM_NODES(1)
    ) u_sw (
        .clk    (clk),
        .reset  (rst_sw),
        .seed_ID(seed_sw),
        .state  (state_sw)
    );

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic [15:0] lf;
    } exp_t;

    typedef struct {
        int         edge_n;
        logic [2:0] st;
    } vec_t;

    exp_t        sbq[$];
    vec_t        vt[12];
    logic [2:0]  obs[0:63];
    logic [15:0] obs_lf[0:63];
    int          nvec  = 0;
    int          nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // expected phase after edge n of a run with L sites and N nodes
    function automatic logic [2:0] exp_st(input int n, input int l,
                                          input int nn);
        int m;
        int r;
        if (n == 0) return IDLE;
        if (n == 1) return SEED;
        if (n < 2 + l) return ROOT;
        m = n - 2 - l;
        if (m >= nn * (l + 2)) return DONE;
        r = m % (l + 2);
        if (r < l) return EVOLVE;
        if (r == l) return WRITE;
        return NEXT;
    endfunction

    // release reset and follow the default-size DUT for nedges edges
    task automatic run_main(input logic [7:0] seed, input int nedges,
                            input bit wiggle, input bit rec);
        logic [15:0] m_lf;
        logic [2:0]  prev;
        exp_t        e;
        exp_t        g;
        m_lf    = 16'hACE1;
        seed_ID = seed;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= nedges; k++) begin
            prev = exp_st(k - 1, 8, 3);
            if (wiggle && (prev == ROOT || prev == EVOLVE || prev == DONE))
                seed_ID = 8'($urandom);
            case (prev)
                SEED:         m_lf = {seed, ~seed};
                ROOT, EVOLVE: m_lf = step(m_lf);
                default:      ;
            endcase
            e.name = $sformatf("s%h e%0d", seed, k);
            e.st   = exp_st(k, 8, 3);
            e.lf   = m_lf;
            sbq.push_back(e);
            @(posedge clk);
            #1;
            g = sbq.pop_front();
            chk({g.name, " state"}, 32'(state), 32'(g.st));
            chk({g.name, " lfsr"}, 32'(u_dut.lfsr), 32'(g.lf));
            if (rec && k < 64) begin
                obs[k]    = state;
                obs_lf[k] = u_dut.lfsr;
            end
        end
    endtask

    initial begin
        vt[0]  = '{0,  IDLE};
        vt[1]  = '{1,  SEED};
        vt[2]  = '{2,  ROOT};
        vt[3]  = '{9,  ROOT};
        vt[4]  = '{10, EVOLVE};
        vt[5]  = '{17, EVOLVE};
        vt[6]  = '{18, WRITE};
        vt[7]  = '{19, NEXT};
        vt[8]  = '{20, EVOLVE};
        vt[9]  = '{39, NEXT};
        vt[10] = '{40, DONE};
        vt[11] = '{44, DONE};

        reset   = 1'b0;
        rst_sw  = 1'b0;
        seed_ID = 8'h00;
        seed_sw = 8'hC3;

        // reset held with clock running
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst hold state", 32'(state), 32'(IDLE));
        end
        chk("rst lfsr", 32'(u_dut.lfsr), 32'hACE1);
        chk("rst node_cnt", 32'(u_dut.node_cnt), 32'd0);
        chk("rst site_cnt", 32'(u_dut.site_cnt), 32'd0);
        obs[0] = state;

        // full default run, seed 00
        run_main(8'h00, 45, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++)
            chk($sformatf("tbl e%0d", vt[i].edge_n),
                32'(obs[vt[i].edge_n]), 32'(vt[i].st));
        chk("seed00 e2", 32'(obs_lf[2]), 32'h00FF);
        chk("seed00 e3", 32'(obs_lf[3]), 32'hB47F);

        // seed 5A with seed_ID churn in ROOT/EVOLVE/DONE, long DONE hold
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_main(8'h5A, 63, 1'b1, 1'b1);
        chk("seed5A e2", 32'(obs_lf[2]), 32'h5AA5);
        chk("seed5A e3", 32'(obs_lf[3]), 32'h9952);
        chk("hold e63", 32'(obs[63]), 32'(DONE));

        // async reset in second EVOLVE, checked before next edge
        reset = 1'b0;
        run_main(8'h33, 25, 1'b1, 1'b0);
        chk("mid e25 state", 32'(state), 32'(EVOLVE));
        chk("mid e25 node", 32'(u_dut.node_cnt), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async state", 32'(state), 32'(IDLE));
        chk("async lfsr", 32'(u_dut.lfsr), 32'hACE1);
        chk("async node", 32'(u_dut.node_cnt), 32'd0);
        chk("async site", 32'(u_dut.site_cnt), 32'd0);
        run_main(8'hA7, 45, 1'b0, 1'b0);
        chk("replay node", 32'(u_dut.node_cnt), 32'd2);

        // SEQ_LEN=1, NUM_NODES=1 instance
        @(negedge clk);
        rst_sw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            exp_t e;
            exp_t g;
            e.name = $sformatf("sweep e%0d", k);
            e.st   = exp_st(k, 1, 1);
            e.lf   = 16'h0000;
            sbq.push_back(e);
            @(posedge clk);
            #1;
            g = sbq.pop_front();
            chk(g.name, 32'(state_sw), 32'(g.st));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
